egd_bit_feeder: RTL and testbench

Bitstream alignment buffer that sits directly upstream of the exp-Golomb decoder core. It accepts 16-bit bitstream words through a valid/ready handshake and keeps up to 48 bits buffered. It presents the decoder with an MSB-first 32-bit window of the next unconsumed bits. The decoder retires a variable number of bits (0..32) per cycle, and the buffer realigns and refills behind it.

---
 rtl/egd_pkg.sv | 24 ++
 rtl/egd_bit_shifter.sv | 16 +
 rtl/egd_bit_feeder.sv | 151 +++++++++++++++
 tb/tb_egd_bit_feeder.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/egd_pkg.sv
// Shared definitions for the exp-Golomb decode path.
// Holds the word/window/buffer widths, the fill/consume-length width and
// the consume-legality helper used by the bit feeder.
package egd_pkg;

  localparam int WORD_W = 16;
  localparam int WIN_W  = 32;
  localparam int BUF_W  = 48;
  localparam int FILL_W = 6;

  // Number of bits the decoder asks to retire in one cycle (0..32 legal).
  typedef logic [FILL_W-1:0] cons_len_t;
  // Count of valid bits held in the buffer (0..48).
  typedef logic [FILL_W-1:0] fill_t;

  // A consume is legal when it fits the window and does not exceed the
  // bits actually buffered.
  function automatic logic cons_legal(input cons_len_t len, input fill_t fill);
    logic ok;
    ok = (len <= 6'd32) && (len <= fill);
    return ok;
  endfunction

endpackage

// File: rtl/egd_bit_shifter.sv
// Purely combinational 48-bit left shifter, zero fill from the right.
// Ports:
//   data    - 48-bit value to shift
//   shamt   - shift amount, 0..48
//   shifted - data << shamt, truncated to 48 bits
module egd_bit_shifter
  import egd_pkg::*;
(
  input  logic [BUF_W-1:0]  data,
  input  logic [FILL_W-1:0] shamt,
  output logic [BUF_W-1:0]  shifted
);

  assign shifted = data << shamt;

endmodule

// File: rtl/egd_bit_feeder.sv
// Bitstream alignment buffer in front of the exp-Golomb decoder core.
// Accepts 16-bit words (bit 15 earliest) on a valid/ready handshake,
// keeps up to 48 bits MSB-first and presents the next 32 unconsumed bits.
// Ports:
//   wb_clk_i     - clock, rising edge
//   wb_rst_i     - asynchronous active-low reset
//   flush_i      - synchronous clear of buffer, error flag and bit counter
//   in_data_i    - bitstream word
//   in_valid_i   - in_data_i valid
//   in_ready_o   - word can be accepted (fill <= 32)
//   win_o        - next 32 unconsumed bits, MSB-aligned, zero past fill
//   win_fill_o   - valid buffered bits, 0..48
//   win_valid_o  - fill >= 32
//   cons_len_i   - bits to retire, 0..32
//   cons_valid_i - retire cons_len_i bits this cycle
//   cons_err_o   - sticky illegal-consume flag
//   bit_count_o  - total bits retired since reset/flush, wraps at 2^32
module egd_bit_feeder
  import egd_pkg::*;
(
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic              flush_i,
  input  logic [15:0]       in_data_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  output logic [31:0]       win_o,
  output logic [5:0]        win_fill_o,
  output logic              win_valid_o,
  input  logic [5:0]        cons_len_i,
  input  logic              cons_valid_i,
  output logic              cons_err_o,
  output logic [31:0]       bit_count_o
);

  // Architectural state. Bits of buf_r below the fill level are always
  // zero, so the window reads 0 past fill without extra masking.
  logic [BUF_W-1:0] buf_r;
  fill_t            fill_r;
  logic             ready_r;
  logic             valid_r;
  logic             err_r;
  logic [31:0]      count_r;

  // Next-state and datapath signals
  logic             accept_s;
  logic             legal_s;
  logic             illegal_s;
  fill_t            shamt_s;
  fill_t            rem_s;
  fill_t            ins_amt_s;
  fill_t            fill_next_s;
  logic [BUF_W-1:0] shifted_s;
  logic [BUF_W-1:0] word_ext_s;
  logic [BUF_W-1:0] inserted_s;
  logic [BUF_W-1:0] base_s;
  logic [BUF_W-1:0] buf_next_s;
  logic             err_next_s;
  logic [31:0]      count_next_s;

  // Consume shift: drop the retired bits off the top of the buffer.
  egd_bit_shifter u_cons_shift (
    .data    (buf_r),
    .shamt   (shamt_s),
    .shifted (shifted_s)
  );

  // Insert alignment: the zero-extended word sits at the LSBs and is
  // shifted up by (32 - remaining) so its MSB lands right after the
  // remaining bits. Remaining is at most 32 whenever a word is accepted.
  egd_bit_shifter u_ins_shift (
    .data    (word_ext_s),
    .shamt   (ins_amt_s),
    .shifted (inserted_s)
  );

  // Handshake, consume legality and next buffer/fill/flag/counter values
  always_comb begin
    word_ext_s = {32'd0, in_data_i};
    accept_s   = in_valid_i & ready_r;
    legal_s    = cons_valid_i & cons_legal(cons_len_i, fill_r);
    illegal_s  = cons_valid_i & ~legal_s;

    if (legal_s) begin
      shamt_s = cons_len_i;
    end else begin
      shamt_s = 6'd0;
    end

    // Flush overrides any consume: start again from an empty buffer.
    if (flush_i) begin
      base_s = {BUF_W{1'b0}};
      rem_s  = 6'd0;
    end else begin
      base_s = shifted_s;
      rem_s  = fill_r - shamt_s;
    end

    ins_amt_s = 6'd32 - rem_s;

    if (accept_s) begin
      buf_next_s  = base_s | inserted_s;
      fill_next_s = rem_s + 6'd16;
    end else begin
      buf_next_s  = base_s;
      fill_next_s = rem_s;
    end

    if (flush_i) begin
      err_next_s   = 1'b0;
      count_next_s = 32'd0;
    end else if (legal_s) begin
      err_next_s   = err_r;
      count_next_s = count_r + {26'd0, cons_len_i};
    end else if (illegal_s) begin
      err_next_s   = 1'b1;
      count_next_s = count_r;
    end else begin
      err_next_s   = err_r;
      count_next_s = count_r;
    end
  end

  // State update; ready/valid are registered from the next fill so they
  // never see a same-cycle input.
  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      buf_r   <= {BUF_W{1'b0}};
      fill_r  <= 6'd0;
      ready_r <= 1'b1;
      valid_r <= 1'b0;
      err_r   <= 1'b0;
      count_r <= 32'd0;
    end else begin
      buf_r   <= buf_next_s;
      fill_r  <= fill_next_s;
      ready_r <= (fill_next_s <= 6'd32);
      valid_r <= (fill_next_s >= 6'd32);
      err_r   <= err_next_s;
      count_r <= count_next_s;
    end
  end

  assign in_ready_o  = ready_r;
  assign win_o       = buf_r[BUF_W-1 -: WIN_W];
  assign win_fill_o  = fill_r;
  assign win_valid_o = valid_r;
  assign cons_err_o  = err_r;
  assign bit_count_o = count_r;

endmodule

// File: tb/tb_egd_bit_feeder.sv
// Scoreboard bench for egd_bit_feeder: the driver pushes hand-computed
// expected output snapshots after each edge, a monitor pops and compares
// them on the following falling edge.
module tb_egd_bit_feeder;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic [15:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] win;
  logic [5:0]  win_fill;
  logic        win_valid;
  logic [5:0]  cons_len;
  logic        cons_valid;
  logic        cons_err;
  logic [31:0] bit_count;

  typedef struct {
    string       nm;
    logic [31:0] w;
    logic [5:0]  f;
    logic        rdy;
    logic        vld;
    logic        err;
    logic [31:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_mis = 0;

  egd_bit_feeder dut (
    .wb_clk_i     (clk),
    .wb_rst_i     (rst_n),
    .flush_i      (flush),
    .in_data_i    (in_data),
    .in_valid_i   (in_valid),
    .in_ready_o   (in_ready),
    .win_o        (win),
    .win_fill_o   (win_fill),
    .win_valid_o  (win_valid),
    .cons_len_i   (cons_len),
    .cons_valid_i (cons_valid),
    .cons_err_o   (cons_err),
    .bit_count_o  (bit_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: compare one expected snapshot per falling edge
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      n_cmp++;
      if (win !== e.w || win_fill !== e.f || in_ready !== e.rdy ||
          win_valid !== e.vld || cons_err !== e.err || bit_count !== e.cnt) begin
        n_mis++;
        $display("FAIL %s: got win=%h fill=%0d rdy=%b vld=%b err=%b cnt=%0d, want win=%h fill=%0d rdy=%b vld=%b err=%b cnt=%0d",
                 e.nm, win, win_fill, in_ready, win_valid, cons_err, bit_count,
                 e.w, e.f, e.rdy, e.vld, e.err, e.cnt);
      end
    end
  end

  task automatic push_exp(input string nm, input logic [31:0] w, input logic [5:0] f,
                          input logic rdy, input logic vld, input logic err,
                          input logic [31:0] cnt);
    exp_t e;
    e.nm = nm; e.w = w; e.f = f; e.rdy = rdy; e.vld = vld; e.err = err; e.cnt = cnt;
    exp_q.push_back(e);
  endtask

  task automatic drive(input logic fl, input logic iv, input logic [15:0] d,
                       input logic cv, input logic [5:0] len);
    flush = fl; in_valid = iv; in_data = d; cons_valid = cv; cons_len = len;
  endtask

  // Clock one edge with the driven inputs, then queue the expected result.
  task automatic step(input string nm, input logic [31:0] w, input logic [5:0] f,
                      input logic rdy, input logic vld, input logic err,
                      input logic [31:0] cnt);
    @(posedge clk);
    #1;
    push_exp(nm, w, f, rdy, vld, err, cnt);
  endtask

  initial begin
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 16'h0000, 1'b0, 6'd0);
    push_exp("reset", 32'h0, 6'd0, 1'b1, 1'b0, 1'b0, 32'd0);
    @(negedge clk);
    #1;
    rst_n = 1'b1;

    // Basic fill and first consume
    drive(1'b0, 1'b1, 16'hA5C3, 1'b0, 6'd0);
    step("push1", 32'hA5C30000, 6'd16, 1'b1, 1'b0, 1'b0, 32'd0);
    drive(1'b0, 1'b1, 16'h0F0F, 1'b0, 6'd0);
    step("push2", 32'hA5C30F0F, 6'd32, 1'b1, 1'b1, 1'b0, 32'd0);
    drive(1'b0, 1'b0, 16'h0000, 1'b1, 6'd3);
    step("cons3", 32'h2E187878, 6'd29, 1'b1, 1'b0, 1'b0, 32'd3);
    drive(1'b1, 1'b0, 16'h0000, 1'b0, 6'd0);
    step("flush_a", 32'h0, 6'd0, 1'b1, 1'b0, 1'b0, 32'd0);

    // Full boundary and backpressure
    drive(1'b0, 1'b1, 16'h1111, 1'b0, 6'd0);
    step("fill16", 32'h11110000, 6'd16, 1'b1, 1'b0, 1'b0, 32'd0);
    drive(1'b0, 1'b1, 16'h2222, 1'b0, 6'd0);
    step("fill32", 32'h11112222, 6'd32, 1'b1, 1'b1, 1'b0, 32'd0);
    drive(1'b0, 1'b1, 16'h3333, 1'b0, 6'd0);
    step("fill48", 32'h11112222, 6'd48, 1'b0, 1'b1, 1'b0, 32'd0);
    drive(1'b0, 1'b1, 16'h4444, 1'b0, 6'd0);
    step("held", 32'h11112222, 6'd48, 1'b0, 1'b1, 1'b0, 32'd0);
    drive(1'b0, 1'b1, 16'h4444, 1'b1, 6'd16);
    step("drain16", 32'h22223333, 6'd32, 1'b1, 1'b1, 1'b0, 32'd16);
    drive(1'b0, 1'b1, 16'h4444, 1'b0, 6'd0);
    step("accept4", 32'h22223333, 6'd48, 1'b0, 1'b1, 1'b0, 32'd16);

    // Simultaneous accept and consume; oversize consume
    drive(1'b1, 1'b0, 16'h0000, 1'b0, 6'd0);
    step("flush_b", 32'h0, 6'd0, 1'b1, 1'b0, 1'b0, 32'd0);
    drive(1'b0, 1'b1, 16'h1234, 1'b0, 6'd0);
    step("p1234", 32'h12340000, 6'd16, 1'b1, 1'b0, 1'b0, 32'd0);
    drive(1'b0, 1'b1, 16'h5678, 1'b0, 6'd0);
    step("p5678", 32'h12345678, 6'd32, 1'b1, 1'b1, 1'b0, 32'd0);
    drive(1'b0, 1'b1, 16'hFFFF, 1'b1, 6'd16);
    step("acc_cons16", 32'h5678FFFF, 6'd32, 1'b1, 1'b1, 1'b0, 32'd16);
    drive(1'b0, 1'b0, 16'h0000, 1'b1, 6'd33);
    step("cons33_err", 32'h5678FFFF, 6'd32, 1'b1, 1'b1, 1'b1, 32'd16);

    // Flush with a word in the same cycle, then overdrawn consume
    drive(1'b1, 1'b1, 16'hABCD, 1'b0, 6'd0);
    step("flush_load", 32'hABCD0000, 6'd16, 1'b1, 1'b0, 1'b0, 32'd0);
    drive(1'b0, 1'b0, 16'h0000, 1'b1, 6'd12);
    step("cons12", 32'hD0000000, 6'd4, 1'b1, 1'b0, 1'b0, 32'd12);
    drive(1'b0, 1'b0, 16'h0000, 1'b1, 6'd5);
    step("cons5_err", 32'hD0000000, 6'd4, 1'b1, 1'b0, 1'b1, 32'd12);
    drive(1'b1, 1'b0, 16'h0000, 1'b0, 6'd0);
    step("flush_c", 32'h0, 6'd0, 1'b1, 1'b0, 1'b0, 32'd0);

    // Empty boundary
    drive(1'b0, 1'b0, 16'h0000, 1'b1, 6'd0);
    step("cons0_empty", 32'h0, 6'd0, 1'b1, 1'b0, 1'b0, 32'd0);
    drive(1'b0, 1'b0, 16'h0000, 1'b1, 6'd1);
    step("cons1_empty", 32'h0, 6'd0, 1'b1, 1'b0, 1'b1, 32'd0);
    drive(1'b1, 1'b0, 16'h0000, 1'b0, 6'd0);
    step("flush_d", 32'h0, 6'd0, 1'b1, 1'b0, 1'b0, 32'd0);

    // Reach fill 40, then flush with word and consume together. At fill 40
    // in_ready is low, so the word is taken on the cycle after the flush.
    drive(1'b0, 1'b1, 16'h1111, 1'b0, 6'd0);
    step("f40_a", 32'h11110000, 6'd16, 1'b1, 1'b0, 1'b0, 32'd0);
    drive(1'b0, 1'b1, 16'h2222, 1'b0, 6'd0);
    step("f40_b", 32'h11112222, 6'd32, 1'b1, 1'b1, 1'b0, 32'd0);
    drive(1'b0, 1'b1, 16'h3333, 1'b1, 6'd8);
    step("acc_cons8", 32'h11222233, 6'd40, 1'b0, 1'b1, 1'b0, 32'd8);
    drive(1'b1, 1'b1, 16'hBEEF, 1'b1, 6'd8);
    step("flush_full", 32'h0, 6'd0, 1'b1, 1'b0, 1'b0, 32'd0);
    drive(1'b0, 1'b1, 16'hBEEF, 1'b0, 6'd0);
    step("beef_load", 32'hBEEF0000, 6'd16, 1'b1, 1'b0, 1'b0, 32'd0);
    drive(1'b0, 1'b0, 16'h0000, 1'b0, 6'd0);

    // Asynchronous reset mid-stream
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    push_exp("rst_mid", 32'h0, 6'd0, 1'b1, 1'b0, 1'b0, 32'd0);
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    drive(1'b0, 1'b1, 16'h1111, 1'b0, 6'd0);
    step("post_rst", 32'h11110000, 6'd16, 1'b1, 1'b0, 1'b0, 32'd0);
    drive(1'b0, 1'b0, 16'h0000, 1'b0, 6'd0);

    // Drain the scoreboard with a bounded wait
    for (int i = 0; i < 10; i++) begin
      if (exp_q.size() > 0) @(negedge clk);
    end
    #1;
    if (exp_q.size() > 0) begin
      n_mis++;
      $display("FAIL drain_timeout: %0d entries left, want 0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
